uart_rx_fc: RTL

- UART receive front end with hardware flow control.
- Oversamples the serial rx line, deframes 8N1 characters and buffers them in a small first-word-fall-through FIFO.
- Drives rx_done and rts_n, the two signals consumed by the downstream rx checker and the host interface.
- Sits between the pad-side uart interface rx pin and the host read port.

---
 rtl/uart_rx_fc.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fc.sv
// uart_rx_fc: 8N1 UART receiver (2-flop sync, oversampled deframer) into a FWFT buffer; rx_done 1 clk after the stop mid-sample.
// Backpressure: rts_n rises when free entries <= RTS_MARGIN, a full buffer drops frames with overrun_err; UART_RX_PARITY_EN adds even parity.
module uart_rx_fc #(
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int RTS_MARGIN = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic [DIV_W-1:0]            baud_div_i,
  input  logic                        rx_i,
  input  logic                        rd_en_i,
  output logic [7:0]                  rx_data_o,
  output logic                        rx_valid_o,
  output logic                        rx_done_o,
  output logic                        rts_n_o,
  output logic                        frame_err_o,
  output logic                        overrun_err_o,
  output logic                        parity_err_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_TICK = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] MARGIN_C  = CW'(RTS_MARGIN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_e;

  state_e           state_q, state_d;
  logic             rx_s1_q, rx_s2_q, rx_s3_q;
  logic [DIV_W-1:0] div_lim, div_lim_q, div_cnt_q, div_cnt_d;
  logic             tick, div_clr;
  logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             push, par_bad;
  logic             done_q, done_d, ferr_q, ferr_d, oerr_q, oerr_d, perr_q, perr_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             full, pop, rts_n_q;

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  assign par_bad = ^{shift_q, par_q};
`else
  assign par_bad = 1'b0;
`endif

  // The divisor is latched only at a wrap so a live baud_div change never truncates a tick.
  assign div_lim = (baud_div_i == '0) ? DIV_W'(1) : baud_div_i;
  assign tick    = (div_cnt_q == div_lim_q - DIV_W'(1));

  always_comb begin
    div_cnt_d = div_cnt_q + DIV_W'(1);
    if (div_clr || tick) div_cnt_d = '0;
  end

  assign full = (count_q == DEPTH_C);
  assign pop  = rd_en_i && (count_q != '0);

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    div_clr    = 1'b0;
    push       = 1'b0;
    done_d     = 1'b0;
    ferr_d     = 1'b0;
    oerr_d     = 1'b0;
    perr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d      = par_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (rx_s3_q && !rx_s2_q) begin
          div_clr    = 1'b1;
          tick_cnt_d = '0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          if (tick_cnt_q == HALF_TICK) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = rx_s2_q ? S_IDLE : S_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (tick_cnt_q == LAST_TICK) begin
            tick_cnt_d = '0;
            shift_d    = {rx_s2_q, shift_q[7:1]};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          if (tick_cnt_q == LAST_TICK) begin
            tick_cnt_d = '0;
            par_d      = rx_s2_q;
            state_d    = S_STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          if (tick_cnt_q == LAST_TICK) begin
            tick_cnt_d = '0;
            state_d    = S_IDLE;
            if (!rx_s2_q) begin
              ferr_d  = 1'b1;
              state_d = S_BREAK;
            end else if (par_bad) begin
              perr_d = 1'b1;
            end else if (full) begin
              oerr_d = 1'b1;
            end else begin
              push   = 1'b1;
              done_d = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
      S_BREAK: begin
        if (rx_s2_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      div_cnt_q  <= '0;
      div_lim_q  <= div_lim;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
      oerr_q     <= 1'b0;
      perr_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rts_n_q    <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rx_s1_q    <= rx_i;
      rx_s2_q    <= rx_s1_q;
      rx_s3_q    <= rx_s2_q;
      div_cnt_q  <= div_cnt_d;
      if (div_clr || tick) div_lim_q <= div_lim;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
      oerr_q     <= oerr_d;
      perr_q     <= perr_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q    <= count_d;
      rts_n_q    <= ((DEPTH_C - count_q) <= MARGIN_C);
`ifdef UART_RX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= shift_q;
  end

  assign rx_valid_o    = (count_q != '0);
  assign rx_data_o     = rx_valid_o ? mem_q[rd_ptr_q] : 8'h00;
  assign fifo_count_o  = count_q;
  assign rts_n_o       = rts_n_q;
  assign rx_done_o     = done_q;
  assign frame_err_o   = ferr_q;
  assign overrun_err_o = oerr_q;
  assign parity_err_o  = perr_q;

endmodule
